// File: rtl/ifetch_unit.sv
// Instruction fetch unit: single-outstanding memory requests feeding a 2-entry {word, pc} FIFO toward decode.
// Optional HALT-opcode detection is compiled in when IFETCH_HALT_DETECT_EN is defined.
module ifetch_unit #(
  parameter int              PC_W     = 9,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  input  logic            redirect,
  input  logic [PC_W-1:0] redirect_pc,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [31:0]     inst,
  output logic [PC_W-1:0] inst_pc,
  output logic            halted
);

  localparam logic [6:0] HALT_OPCODE = 7'b1111111;

  typedef struct packed {
    logic [31:0]     word;
    logic [PC_W-1:0] pc;
  } entry_t;

  entry_t          fifo_q [2];
  logic            rd_ptr_q;
  logic            wr_ptr_q;
  logic [1:0]      count_q;
  logic [PC_W-1:0] fetch_pc_q;
  logic [PC_W-1:0] req_pc_q;
  logic            outstanding_q;
  logic            discard_q;

  logic   in_fetch;
  logic   halt_pop;
  logic   redir;
  logic   fire;
  logic   push;
  logic   pop;
  logic   flush;
  entry_t head;

  assign head = fifo_q[rd_ptr_q];

`ifdef IFETCH_HALT_DETECT_EN
  typedef enum logic {
    S_FETCH,
    S_HALTED
  } state_t;

  state_t state_q;
  state_t state_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  // NOTE: state_d gets its default first so no path through this block can infer a latch.
  always_comb begin
    state_d = state_q;
    if (state_q == S_FETCH && halt_pop) state_d = S_HALTED;
  end

  // A redirect in the same cycle as the HALT pop wins: the HALT is treated as squashed.
  assign in_fetch = (state_q == S_FETCH);
  assign halt_pop = pop && (head.word[6:0] == HALT_OPCODE) && !redirect;
  assign halted   = (state_q == S_HALTED);
`else
  assign in_fetch = 1'b1;
  assign halt_pop = 1'b0;
  assign halted   = 1'b0;
`endif

  assign redir      = redirect && in_fetch;
  assign inst_valid = in_fetch && (count_q != 2'd0);
  assign pop        = inst_valid && inst_ready;

  // Requests are held off while reset is asserted so the port is quiet during reset.
  assign imem_req  = rst_n && in_fetch && !outstanding_q && !count_q[1] && !redirect && !halt_pop;
  assign imem_addr = fetch_pc_q;
  assign fire      = imem_req && imem_gnt;

  assign push  = imem_rvalid && outstanding_q && !discard_q;
  assign flush = redir || halt_pop || !in_fetch;

  assign inst    = inst_valid ? head.word : '0;
  assign inst_pc = inst_valid ? head.pc   : '0;

  // NOTE: all state below updates with non-blocking assignments so every flop sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q    <= RESET_PC;
      req_pc_q      <= RESET_PC;
      outstanding_q <= 1'b0;
      discard_q     <= 1'b0;
    end else begin
      if (redir)     fetch_pc_q <= redirect_pc;
      else if (fire) fetch_pc_q <= fetch_pc_q + PC_W'(4);

      if (fire) begin
        outstanding_q <= 1'b1;
        discard_q     <= 1'b0;
        req_pc_q      <= fetch_pc_q;
      end else if (imem_rvalid && outstanding_q) begin
        outstanding_q <= 1'b0;
        discard_q     <= 1'b0;
      end else if (redir && outstanding_q) begin
        discard_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q  <= 2'd0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
    end else if (flush) begin
      count_q  <= 2'd0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= ~wr_ptr_q;
      if (pop)  rd_ptr_q <= ~rd_ptr_q;
      case ({push, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  // NOTE: FIFO storage has no reset; count_q alone says which entries are meaningful.
  always_ff @(posedge clk) begin
    if (push && !flush) fifo_q[wr_ptr_q] <= '{word: imem_rdata, pc: req_pc_q};
  end

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit: vector table for start-up/redirect timing plus
// hand-written sequences for backpressure, HALT, PC wrap and mid-response reset.
module tb_ifetch_unit;

  localparam int PC_W = 9;
  localparam logic [PC_W-1:0] RESET_PC = '0;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            imem_req;
  logic [PC_W-1:0] imem_addr;
  logic            imem_gnt = 1'b0;
  logic            imem_rvalid = 1'b0;
  logic [31:0]     imem_rdata = '0;
  logic            redirect = 1'b0;
  logic [PC_W-1:0] redirect_pc = '0;
  logic            inst_valid;
  logic            inst_ready = 1'b0;
  logic [31:0]     inst;
  logic [PC_W-1:0] inst_pc;
  logic            halted;

  ifetch_unit #(.PC_W(PC_W), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst(inst), .inst_pc(inst_pc), .halted(halted)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Memory model and delivery scoreboard state.
  logic            resp_pend = 1'b0;
  logic [PC_W-1:0] resp_addr = '0;
  logic            rv_stall  = 1'b0;
  logic            halt_at_c = 1'b0;
  logic [PC_W-1:0] exp_next  = '0;

  typedef struct {
    logic            ready;
    logic            redir;
    logic [PC_W-1:0] rpc;
    logic            stall;
    logic            exp_req;
    logic [PC_W-1:0] exp_addr;
    logic            exp_valid;
    logic [PC_W-1:0] exp_pc;
    logic [31:0]     exp_inst;
  } vec_t;

  vec_t vecs [14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [PC_W-1:0] a);
    if (a == 9'h000)                   return 32'h00500093;
    else if (a == 9'h004)              return 32'h00100113;
    else if (a == 9'h00C && halt_at_c) return 32'h0000007F;
    else                               return 32'hA000_0000 | {23'd0, a};
  endfunction

  // Called just after a falling edge: present memory inputs, then let outputs settle.
  task automatic drive();
    imem_gnt = 1'b1;
    if (resp_pend && !rv_stall) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_word(resp_addr);
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = 32'hDEAD_BEEF;
    end
    #1;
  endtask

  // Score this cycle's handshakes, then move to the next falling edge.
  task automatic advance();
    if (inst_valid && inst_ready) begin
      check("deliver_pc", 32'(inst_pc), 32'(exp_next));
      check("deliver_inst", inst, mem_word(exp_next));
      exp_next = exp_next + 9'd4;
    end
    if (redirect) exp_next = redirect_pc;
    if (imem_rvalid) resp_pend = 1'b0;
    if (imem_req && imem_gnt) begin
      check("one_outstanding", 32'(resp_pend), 32'd0);
      resp_pend = 1'b1;
      resp_addr = imem_addr;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n       = 1'b0;
    redirect    = 1'b0;
    imem_rvalid = 1'b0;
    imem_gnt    = 1'b0;
    resp_pend   = 1'b0;
    rv_stall    = 1'b0;
    exp_next    = RESET_PC;
    #1;
    check("rst_req", 32'(imem_req), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    check("rst_addr", 32'(imem_addr), 32'(RESET_PC));
    check("rst_valid", 32'(inst_valid), 32'd0);
    check("rst_inst", inst, 32'd0);
    check("rst_inst_pc", 32'(inst_pc), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    rst_n = 1'b1;
  endtask

  // Stops (without advancing) in the cycle where the entry at target sits at the FIFO head.
  task automatic run_until_pc(input logic [PC_W-1:0] target);
    bit found = 1'b0;
    int budget = 0;
    inst_ready = 1'b1;
    while (!found && budget < 40) begin
      drive();
      if (inst_valid && inst_pc == target) found = 1'b1;
      else begin
        advance();
        budget++;
      end
    end
    check("reach_pc", 32'(found), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    //          rdy redir rpc     stall req  addr    vld  pc      inst
    vecs[0]  = '{1, 0, 9'h000, 0, 1, 9'h000, 0, 9'h000, 32'h0};
    vecs[1]  = '{1, 0, 9'h000, 0, 0, 9'h004, 0, 9'h000, 32'h0};
    vecs[2]  = '{1, 0, 9'h000, 0, 1, 9'h004, 1, 9'h000, 32'h00500093};
    vecs[3]  = '{1, 0, 9'h000, 0, 0, 9'h008, 0, 9'h000, 32'h0};
    vecs[4]  = '{1, 0, 9'h000, 0, 1, 9'h008, 1, 9'h004, 32'h00100113};
    vecs[5]  = '{1, 1, 9'h040, 1, 0, 9'h00C, 0, 9'h000, 32'h0};
    vecs[6]  = '{1, 0, 9'h000, 0, 0, 9'h040, 0, 9'h000, 32'h0};
    vecs[7]  = '{1, 0, 9'h000, 0, 1, 9'h040, 0, 9'h000, 32'h0};
    vecs[8]  = '{1, 0, 9'h000, 0, 0, 9'h044, 0, 9'h000, 32'h0};
    vecs[9]  = '{1, 0, 9'h000, 0, 1, 9'h044, 1, 9'h040, 32'hA0000040};
    vecs[10] = '{1, 1, 9'h080, 0, 0, 9'h048, 0, 9'h000, 32'h0};
    vecs[11] = '{1, 0, 9'h000, 0, 1, 9'h080, 0, 9'h000, 32'h0};
    vecs[12] = '{1, 0, 9'h000, 0, 0, 9'h084, 0, 9'h000, 32'h0};
    vecs[13] = '{1, 0, 9'h000, 0, 1, 9'h084, 1, 9'h080, 32'hA0000080};

    @(negedge clk);
    do_reset();

    // Start-up, redirect with a stalled response, redirect colliding with rvalid.
    for (int i = 0; i < 14; i++) begin
      inst_ready  = vecs[i].ready;
      redirect    = vecs[i].redir;
      redirect_pc = vecs[i].rpc;
      rv_stall    = vecs[i].stall;
      drive();
      check($sformatf("v%0d_req", i), 32'(imem_req), 32'(vecs[i].exp_req));
      check($sformatf("v%0d_addr", i), 32'(imem_addr), 32'(vecs[i].exp_addr));
      check($sformatf("v%0d_valid", i), 32'(inst_valid), 32'(vecs[i].exp_valid));
      if (vecs[i].exp_valid) begin
        check($sformatf("v%0d_pc", i), 32'(inst_pc), 32'(vecs[i].exp_pc));
        check($sformatf("v%0d_inst", i), inst, vecs[i].exp_inst);
      end
      advance();
    end
    redirect = 1'b0;
    rv_stall = 1'b0;

    // Backpressure: FIFO fills to two entries and fetch stops with nothing in flight.
    do_reset();
    run_until_pc(9'h008);
    inst_ready = 1'b0;
    #1;
    advance();
    for (int i = 0; i < 9; i++) begin
      drive();
      advance();
    end
    drive();
    check("bp_req", 32'(imem_req), 32'd0);
    check("bp_valid", 32'(inst_valid), 32'd1);
    check("bp_head_pc", 32'(inst_pc), 32'h008);
    check("bp_outstanding", 32'(resp_pend), 32'd0);
    advance();
    run_until_pc(9'h014);
    check("bp_after_inst", inst, 32'hA0000014);
    inst_ready = 1'b0;
    #1;
    advance();

    // HALT opcode at 0x00C.
    halt_at_c = 1'b1;
    do_reset();
    run_until_pc(9'h00C);
    check("halt_word", inst, 32'h0000007F);
    check("halt_pre", 32'(halted), 32'd0);
    advance();
`ifdef IFETCH_HALT_DETECT_EN
    for (int i = 0; i < 5; i++) begin
      redirect    = (i == 1 || i == 2);
      redirect_pc = 9'h040;
      drive();
      check($sformatf("halted_%0d", i), 32'(halted), 32'd1);
      check($sformatf("halted_req_%0d", i), 32'(imem_req), 32'd0);
      check($sformatf("halted_valid_%0d", i), 32'(inst_valid), 32'd0);
      advance();
    end
    redirect = 1'b0;
`else
    run_until_pc(9'h010);
    check("nohalt_halted", 32'(halted), 32'd0);
    check("nohalt_inst", inst, 32'hA0000010);
    advance();
`endif
    halt_at_c = 1'b0;

    // PC wrap at the top of a 9-bit address space.
    do_reset();
    redirect    = 1'b1;
    redirect_pc = 9'h1FC;
    drive();
    check("wrap_redir_req", 32'(imem_req), 32'd0);
    advance();
    redirect = 1'b0;
    drive();
    check("wrap_req", 32'(imem_req), 32'd1);
    check("wrap_addr_1fc", 32'(imem_addr), 32'h1FC);
    advance();
    drive();
    check("wrap_addr_000", 32'(imem_addr), 32'h000);
    advance();
    run_until_pc(9'h000);
    check("wrap_inst", inst, 32'h00500093);
    advance();

    // Reset while the response for 0x004 is in flight, then restart from RESET_PC.
    do_reset();
    drive();
    check("restart_req", 32'(imem_req), 32'd1);
    check("restart_addr", 32'(imem_addr), 32'(RESET_PC));
    advance();
    run_until_pc(9'h004);
    check("restart_inst", inst, 32'h00100113);
    advance();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
